// File: rtl/fifo_mem_pkg.sv
// fifo_mem_pkg: default geometry and depth derivation shared by the FIFO files
package fifo_mem_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 3;
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction
   localparam int DEF_DEPTH = fifo_depth(DEF_ADDR_WIDTH);
endpackage

// File: rtl/fifo_mem_ram.sv
// fifo_mem_ram: storage array with a synchronous write port and a registered read port
module fifo_mem_ram
   import fifo_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  w_clk,
   input  logic                  wrst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   // array has no reset so it can map onto plain RAM; only the read register clears
   always_ff @(posedge w_clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge w_clk or posedge wrst)
      if (wrst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_mem.sv
// fifo_mem: synchronous FIFO with wrap-bit pointers, full/empty flags and occupancy count
module fifo_mem
   import fifo_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  w_clk,
   input  logic                  wrst,
   input  logic                  w_en,
   input  logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic [ADDR_WIDTH:0]   count
);
   logic wr_ok, rd_ok;
   // acceptance uses pre-edge flags, so a full FIFO still pops and an empty one still pushes
   assign wr_ok      = w_en && !fifo_full;
   assign rd_ok      = r_en && !fifo_empty;
   assign fifo_empty = wptr == rptr;
   assign fifo_full  = wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0] && wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH];
   assign count      = wptr - rptr;
   always_ff @(posedge w_clk or posedge wrst)
      if (wrst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
      end
   fifo_mem_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .w_clk (w_clk),
      .wrst  (wrst),
      .we    (wr_ok),
      .waddr (wptr[ADDR_WIDTH-1:0]),
      .wdata (data_in),
      .re    (rd_ok),
      .raddr (rptr[ADDR_WIDTH-1:0]),
      .rdata (data_out)
   );
endmodule

// File: tb/tb_fifo_mem.sv
// tb_fifo_mem: directed scoreboard bench for fifo_mem
module tb_fifo_mem;
   localparam int DEPTH = 8;
   logic        w_clk = 0, wrst = 0, w_en = 0, r_en = 0;
   logic [31:0] data_in = 0, data_out;
   logic [3:0]  wptr, rptr, count;
   logic        fifo_full, fifo_empty;
   logic [31:0] q[$];
   logic [31:0] exp_do;
   logic [3:0]  mwp, mrp;
   int          n_chk = 0, n_fail = 0;

   fifo_mem dut (
      .w_clk(w_clk), .wrst(wrst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
      .data_out(data_out), .wptr(wptr), .rptr(rptr), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .count(count)
   );

   always #5 w_clk = ~w_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".wptr"}, 32'(wptr), 32'(mwp));
      chk({tag, ".rptr"}, 32'(rptr), 32'(mrp));
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
      chk({tag, ".full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
      chk({tag, ".data_out"}, data_out, exp_do);
   endtask

   task automatic model_reset();
      q.delete();
      mwp = 0;
      mrp = 0;
      exp_do = 0;
   endtask

   task automatic step(input string tag, input logic we, input logic re, input logic [31:0] d);
      logic wa, ra;
      wa = we && q.size() != DEPTH;
      ra = re && q.size() != 0;
      w_en = we;
      r_en = re;
      data_in = d;
      @(posedge w_clk);
      if (ra) begin
         exp_do = q.pop_front();
         mrp++;
      end
      if (wa) begin
         q.push_back(d);
         mwp++;
      end
      #1;
      w_en = 0;
      r_en = 0;
      chk_all(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      wrst = 1;
      repeat (5) @(posedge w_clk);
      #1;
      chk_all("reset");
      wrst = 0;
      for (int i = 0; i < 7; i++) step("fill7", 1, 0, $urandom);
      step("fill8", 1, 0, $urandom);
      step("write_full", 1, 0, 32'hDEADBEEF);
      for (int i = 0; i < 8; i++) step("drain", 0, 1, 0);
      step("read_empty0", 0, 1, 0);
      step("read_empty1", 0, 1, 0);
      step("rw_empty", 1, 1, $urandom);
      for (int i = 0; i < 4; i++) step("fill5", 1, 0, $urandom);
      for (int i = 0; i < 10; i++) step("rw_steady", 1, 1, $urandom);
      for (int i = 0; i < 3; i++) step("refill", 1, 0, $urandom);
      step("rw_full", 1, 1, 32'hCAFEF00D);
      for (int i = 0; i < 3; i++) step("to4", 0, 1, 0 | 32'h0);
      chk("pre_rst.count", 32'(count), 32'd4);
      #3;
      wrst = 1;
      #1;
      model_reset();
      chk_all("async_rst");
      w_en = 1;
      r_en = 1;
      data_in = 32'h12345678;
      repeat (2) @(posedge w_clk);
      #1;
      chk_all("rst_hold");
      w_en = 0;
      r_en = 0;
      wrst = 0;
      step("post_rst_w", 1, 0, 32'hA5A5A5A5);
      step("post_rst_r", 0, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
